// File: rtl/ds_adc_frontend_pkg.sv
// Shared constants for the delta-sigma ADC front end.
package ds_adc_frontend_pkg;

    // Default output sample width; the counting window is 2**C_DAT_W_DEF ticks.
    localparam int unsigned C_DAT_W_DEF = 8;

endpackage : ds_adc_frontend_pkg

// File: rtl/ds_adc_frontend_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin.
module sync_2ff (
    input  logic CK_i,
    input  logic XARST_i,
    input  logic D_i,
    output logic Q_o
);

    logic r_s1;
    logic r_s2;

    // Metastability filter: capture on every clock edge, independent of any enable.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= D_i;
            r_s2 <= r_s1;
        end
    end

    assign Q_o = r_s2;

endmodule : sync_2ff

// File: rtl/ds_adc_frontend.sv
// First-order delta-sigma ADC front end: samples the comparator, drives the
// integrator feedback bit and counts feedback ones over 2**C_DAT_W ticks.
module ds_adc_frontend
    import ds_adc_frontend_pkg::*;
#(
    parameter int unsigned C_DAT_W = C_DAT_W_DEF
) (
    input  logic               CK_i,
    input  logic               XARST_i,
    input  logic               EN_CK_i,
    input  logic               CLR_i,
    input  logic               CMP_i,
    output logic               FB_o,
    output logic [C_DAT_W-1:0] DAT_o,
    output logic               DAT_EN_o,
    output logic               SAT_o
);

    // One extra bit so a full-scale window (every tick a one) fits without wrap.
    localparam int unsigned C_ACC_W = C_DAT_W + 1;
    localparam logic [C_ACC_W-1:0] C_FULL = {1'b1, {C_DAT_W{1'b0}}};

    logic               w_cmp_s;
    logic [C_DAT_W-1:0] r_ph;
    logic [C_DAT_W-1:0] w_ph_nxt;
    logic [C_ACC_W-1:0] r_acc;
    logic [C_ACC_W-1:0] w_acc_nxt;
    logic [C_ACC_W-1:0] w_sum;
    logic               w_win_end;
    logic               w_full;
    logic               r_fb;
    logic               w_fb_nxt;
    logic [C_DAT_W-1:0] r_dat;
    logic [C_DAT_W-1:0] w_dat_nxt;
    logic               r_dat_en;
    logic               w_dat_en_nxt;
    logic               r_sat;
    logic               w_sat_nxt;

    sync_2ff u_sync_cmp (
        .CK_i    (CK_i),
        .XARST_i (XARST_i),
        .D_i     (CMP_i),
        .Q_o     (w_cmp_s)
    );

    assign w_sum     = r_acc + C_ACC_W'(w_cmp_s);
    assign w_win_end = (r_ph == {C_DAT_W{1'b1}});
    assign w_full    = (w_sum == C_FULL);

    // Next-state: restart beats a tick; a tick at window end publishes the count.
    always_comb begin
        w_ph_nxt     = r_ph;
        w_acc_nxt    = r_acc;
        w_fb_nxt     = r_fb;
        w_dat_nxt    = r_dat;
        w_dat_en_nxt = 1'b0;
        w_sat_nxt    = 1'b0;

        if (CLR_i) begin
            w_ph_nxt  = '0;
            w_acc_nxt = '0;
            w_fb_nxt  = 1'b0;
        end else if (EN_CK_i) begin
            w_fb_nxt = w_cmp_s;
            w_ph_nxt = r_ph + C_DAT_W'(1);
            if (w_win_end) begin
                w_acc_nxt    = '0;
                w_dat_nxt    = w_full ? {C_DAT_W{1'b1}} : w_sum[C_DAT_W-1:0];
                w_sat_nxt    = w_full;
                w_dat_en_nxt = 1'b1;
            end else begin
                w_acc_nxt = w_sum;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_ph     <= '0;
            r_acc    <= '0;
            r_fb     <= 1'b0;
            r_dat    <= '0;
            r_dat_en <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_ph     <= w_ph_nxt;
            r_acc    <= w_acc_nxt;
            r_fb     <= w_fb_nxt;
            r_dat    <= w_dat_nxt;
            r_dat_en <= w_dat_en_nxt;
            r_sat    <= w_sat_nxt;
        end
    end

    assign FB_o     = r_fb;
    assign DAT_o    = r_dat;
    assign DAT_EN_o = r_dat_en;
    assign SAT_o    = r_sat;

endmodule : ds_adc_frontend

// File: tb/tb_ds_adc_frontend.sv
// Bench for ds_adc_frontend with C_DAT_W=4: directed scenarios plus a
// randomized run, all compared every cycle against a window-counting model.
module tb_ds_adc_frontend;

    localparam int unsigned W   = 4;
    localparam int          WIN = 16;

    logic         CK_i = 1'b0;
    logic         XARST_i;
    logic         EN_CK_i;
    logic         CLR_i;
    logic         CMP_i;
    logic         FB_o;
    logic [W-1:0] DAT_o;
    logic         DAT_EN_o;
    logic         SAT_o;

    ds_adc_frontend #(.C_DAT_W(W)) dut (
        .CK_i     (CK_i),
        .XARST_i  (XARST_i),
        .EN_CK_i  (EN_CK_i),
        .CLR_i    (CLR_i),
        .CMP_i    (CMP_i),
        .FB_o     (FB_o),
        .DAT_o    (DAT_o),
        .DAT_EN_o (DAT_EN_o),
        .SAT_o    (SAT_o)
    );

    always #5 CK_i = ~CK_i;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: comparator delay line of two samples, ticks into window, ones seen.
    int       m_d1, m_d2, m_ticks, m_ones;
    logic     m_fb, m_en, m_sat;
    logic [W-1:0] m_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; m_ticks = 0; m_ones = 0;
        m_fb = 1'b0; m_en = 1'b0; m_sat = 1'b0; m_dat = '0;
    endtask

    // One clock edge as the behaviour rules describe it, using the inputs present at that edge.
    task automatic model_edge();
        int cs;
        cs   = m_d2;
        m_d2 = m_d1;
        m_d1 = int'(CMP_i);
        m_en  = 1'b0;
        m_sat = 1'b0;
        if (CLR_i) begin
            m_ticks = 0; m_ones = 0; m_fb = 1'b0;
        end else if (EN_CK_i) begin
            m_fb = cs[0];
            m_ones += cs;
            m_ticks++;
            if (m_ticks == WIN) begin
                m_en    = 1'b1;
                m_sat   = (m_ones == WIN);
                m_dat   = (m_ones > WIN - 1) ? W'(WIN - 1) : W'(m_ones);
                m_ticks = 0;
                m_ones  = 0;
            end
        end
    endtask

    task automatic chk_all();
        chk("fb",     32'(FB_o),     32'(m_fb));
        chk("dat",    32'(DAT_o),    32'(m_dat));
        chk("dat_en", 32'(DAT_EN_o), 32'(m_en));
        chk("sat",    32'(SAT_o),    32'(m_sat));
    endtask

    task automatic step();
        @(posedge CK_i);
        cyc++;
        if (XARST_i) model_edge();
        else         model_reset();
        #1;
        chk_all();
    endtask

    // Step until a strobe is seen; toggle drives CMP_i alternating, en_div gates EN_CK_i.
    task automatic wait_strobe(input int limit, input bit toggle, input int en_div, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (toggle) CMP_i = ~CMP_i;
            EN_CK_i = (en_div <= 1) ? 1'b1 : ((cyc % en_div) == 0);
            step();
            if (DAT_EN_o === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL strobe_timeout cyc=%0d observed=none expected=strobe within %0d", cyc, limit);
        end
    endtask

    initial begin
        int t0, t1, t_clr, t_rel;
        logic [W-1:0] held;

        model_reset();
        XARST_i = 1'b0; EN_CK_i = 1'b1; CLR_i = 1'b0; CMP_i = 1'b1;

        // 1. Reset with comparator high, then release and watch first two windows.
        #2;
        chk("rst_fb", 32'(FB_o), 0);
        chk("rst_dat", 32'(DAT_o), 0);
        chk("rst_en", 32'(DAT_EN_o), 0);
        chk("rst_sat", 32'(SAT_o), 0);
        step(); step(); step();
        XARST_i = 1'b1;
        wait_strobe(40, 1'b0, 1, t0);
        chk("t1_first_dat", 32'(DAT_o), 14);
        chk("t1_first_sat", 32'(SAT_o), 0);
        chk("t1_first_at", 32'(t0), 32'(3 + WIN));
        wait_strobe(40, 1'b0, 1, t1);
        chk("t1_second_dat", 32'(DAT_o), 15);
        chk("t1_second_sat", 32'(SAT_o), 1);
        chk("t1_period", 32'(t1 - t0), 32'(WIN));

        // 2. Comparator low: two windows to flush, then zero count.
        CMP_i = 1'b0;
        wait_strobe(40, 1'b0, 1, t0);
        wait_strobe(40, 1'b0, 1, t0);
        chk("t2_dat", 32'(DAT_o), 0);
        chk("t2_sat", 32'(SAT_o), 0);
        chk("t2_fb", 32'(FB_o), 0);

        // 3. Comparator toggling every cycle: half scale after one settling window.
        wait_strobe(40, 1'b1, 1, t0);
        wait_strobe(40, 1'b1, 1, t0);
        chk("t3_dat_a", 32'(DAT_o), 8);
        wait_strobe(40, 1'b1, 1, t0);
        chk("t3_dat_b", 32'(DAT_o), 8);

        // 4. One tick in four with comparator high: 64-cycle strobe period, full scale.
        CMP_i = 1'b1;
        wait_strobe(200, 1'b0, 4, t0);
        wait_strobe(200, 1'b0, 4, t0);
        wait_strobe(200, 1'b0, 4, t1);
        chk("t4_period", 32'(t1 - t0), 64);
        chk("t4_dat", 32'(DAT_o), 15);
        chk("t4_sat", 32'(SAT_o), 1);

        // 5. Window restart at PH=9 and at PH=15.
        EN_CK_i = 1'b1;
        CMP_i = 1'b0;
        wait_strobe(40, 1'b0, 1, t0);
        for (int ph = 0; ph < 2; ph++) begin
            int stop;
            stop = (ph == 0) ? 9 : 15;
            wait_strobe(40, 1'b0, 1, t0);
            held = DAT_o;
            for (int i = 0; i < stop; i++) step();
            CLR_i = 1'b1;
            step();
            t_clr = cyc;
            CLR_i = 1'b0;
            chk("t5_clr_en", 32'(DAT_EN_o), 0);
            chk("t5_clr_hold", 32'(DAT_o), 32'(held));
            CMP_i = 1'b1;
            wait_strobe(40, 1'b0, 1, t1);
            chk("t5_next_at", 32'(t1 - t_clr), 32'(WIN));
            CMP_i = 1'b0;
        end

        // 6. Asynchronous reset mid-cycle at PH=7.
        CMP_i = 1'b1;
        wait_strobe(40, 1'b0, 1, t0);
        for (int i = 0; i < 7; i++) step();
        #2;
        XARST_i = 1'b0;
        #1;
        model_reset();
        chk("t6_fb", 32'(FB_o), 0);
        chk("t6_dat", 32'(DAT_o), 0);
        chk("t6_en", 32'(DAT_EN_o), 0);
        chk("t6_sat", 32'(SAT_o), 0);
        step();
        XARST_i = 1'b1;
        t_rel = cyc;
        wait_strobe(40, 1'b0, 1, t1);
        chk("t6_first_at", 32'(t1 - t_rel), 32'(WIN));
        chk("t6_first_dat", 32'(DAT_o), 14);

        // Randomized run: comparator, enable and occasional restart.
        for (int i = 0; i < 1500; i++) begin
            CMP_i   = 1'($urandom_range(0, 1));
            EN_CK_i = ($urandom_range(0, 3) != 0);
            CLR_i   = ($urandom_range(0, 63) == 0);
            step();
        end
        CLR_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ds_adc_frontend
